// File: rtl/plp_pkg.sv
// ============================================================================
// Module   : plp_pkg
// Purpose  : Shared constants and types for the instruction fetch slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package plp_pkg;

  localparam logic [31:0] PLP_RESET_PC   = 32'h0000_0000;
  localparam int unsigned PLP_WORD_BYTES = 4;
  localparam int unsigned PLP_INST_W     = 32;

  typedef struct packed {
    logic [31:0]           pc;
    logic [PLP_INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } ifetch_state_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// ============================================================================
// Module   : ifetch_fifo
// Purpose  : DEPTH-entry prefetch queue of {pc, inst} with flush and registered head.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_fifo
  import plp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     head_valid_o,
  output fetch_entry_t             head_o
);

  localparam int unsigned c_aw = $clog2(DEPTH);
  localparam int unsigned c_cw = c_aw + 1;

  fetch_entry_t      mem_q [DEPTH];
  logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]   count_q, count_d;
  logic [c_cw-1:0]   remain;
  logic              pop_eff;
  logic              head_valid_q, head_valid_d;
  fetch_entry_t      head_q, head_d;

  always_comb begin
    pop_eff      = pop_i && (count_q != '0);
    remain       = count_q - c_cw'(pop_eff);
    rd_ptr_d     = rd_ptr_q + c_aw'(pop_eff);
    wr_ptr_d     = wr_ptr_q + c_aw'(push_i);
    count_d      = remain + c_cw'(push_i);
    head_valid_d = head_valid_q;
    head_d       = head_q;
    if (flush_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
    end else begin
      head_valid_d = (count_d != '0);
      // Head is built from next-state so a push into an empty queue is visible next cycle.
      if (remain == '0) begin
        if (push_i) head_d = push_data_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o      = count_q;
  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;

endmodule

`default_nettype wire

// File: rtl/mod_ifetch.sv
// ============================================================================
// Module   : mod_ifetch
// Purpose  : Fetch PC, ROM request/response and prefetch queue feeding decode.
//            Define IFETCH_PERF_EN to add the perf_stall decode-starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_ifetch
  import plp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PLP_RESET_PC,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        rom_ie,
  output logic [31:0] rom_iaddr,
  input  logic [31:0] rom_iout,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned c_cw         = $clog2(DEPTH) + 1;
  localparam int unsigned c_sw         = c_cw + 1;
  localparam logic [c_sw-1:0] c_depth  = c_sw'(DEPTH);
  localparam logic [31:0] c_word       = 32'(PLP_WORD_BYTES);
  localparam logic [31:0] c_align_mask = ~(c_word - 32'd1);

  ifetch_state_t   state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q;
  logic [31:0]     rom_iaddr_q;
  logic            rom_ie_q;
  logic            inflight_q;
  logic            kill_q;
  logic [31:0]     issue_pc;
  logic            issue;
  logic            push;
  logic            pop;
  logic [c_sw-1:0] committed;
  logic [c_cw-1:0] fifo_count;
  logic            head_valid;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // A redirect issues its target in the same cycle, so fetch_pc already advances past it.
  always_comb begin
    state_d    = ST_RUN;
    issue_pc   = (state_q == ST_RESET) ? RESET_PC : fetch_pc_q;
    if (redirect) issue_pc = redirect_pc & c_align_mask;
    push       = inflight_q && !kill_q && !redirect;
    pop        = head_valid && inst_ready && !redirect;
    committed  = c_sw'(fifo_count) + c_sw'(push) - c_sw'(pop) + c_sw'(rom_ie_q);
    if (redirect) committed = '0;
    issue      = (committed < c_depth);
    fetch_pc_d = issue ? (issue_pc + c_word) : issue_pc;
    push_entry = '{pc: req_pc_q, inst: rom_iout};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RESET;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      rom_iaddr_q <= '0;
      rom_ie_q    <= 1'b0;
      inflight_q  <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      rom_ie_q    <= issue;
      if (issue) rom_iaddr_q <= issue_pc;
      inflight_q  <= rom_ie_q;
      req_pc_q    <= rom_iaddr_q;
      kill_q      <= redirect;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .count_o      (fifo_count),
    .head_valid_o (head_valid),
    .head_o       (head)
  );

  assign rom_ie     = rom_ie_q;
  assign rom_iaddr  = rom_iaddr_q;
  assign inst_valid = head_valid;
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_q <= '0;
    end else if (!head_valid && inst_ready && (perf_stall_q != '1)) begin
      perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_stall = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_ifetch.sv
// ============================================================================
// Module   : tb_mod_ifetch
// Purpose  : Scoreboard bench for mod_ifetch (main instance plus a wrap-address instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_ifetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic        rom_ie;
  logic [31:0] rom_iaddr;
  logic [31:0] rom_iout;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  logic        tie_lo    = 1'b0;
  logic        tie_hi    = 1'b1;
  logic [31:0] tie_pc    = 32'h0;
  logic        w_rom_ie;
  logic [31:0] w_rom_iaddr;
  logic [31:0] w_rom_iout;
  logic        w_inst_valid;
  logic [31:0] w_inst_data;
  logic [31:0] w_inst_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] w_perf_stall;
`endif

  mod_ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rom_ie      (rom_ie),
    .rom_iaddr   (rom_iaddr),
    .rom_iout    (rom_iout),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall  (perf_stall)
`endif
  );

  mod_ifetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .redirect    (tie_lo),
    .redirect_pc (tie_pc),
    .rom_ie      (w_rom_ie),
    .rom_iaddr   (w_rom_iaddr),
    .rom_iout    (w_rom_iout),
    .inst_valid  (w_inst_valid),
    .inst_ready  (tie_hi),
    .inst_data   (w_inst_data),
    .inst_pc     (w_inst_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall  (w_perf_stall)
`endif
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  // ROM: one-cycle read latency, junk when not enabled
  always @(posedge clk) begin
    rom_iout   <= rom_ie   ? rom_word(rom_iaddr)   : 32'hDEAD_BEEF;
    w_rom_iout <= w_rom_ie ? rom_word(w_rom_iaddr) : 32'hDEAD_BEEF;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] sb_q[$];
  logic [31:0] exp_pc;
  int          n_issue = 0;
  int          n_pop   = 0;

  task automatic sb_restart(input logic [31:0] pc0);
    sb_q.delete();
    for (int i = 0; i < 64; i++) sb_q.push_back(pc0 + 32'(4 * i));
  endtask

  always @(negedge clk) begin
    if (rst && rom_ie) n_issue++;
    if (rst && !redirect && inst_valid && inst_ready) begin
      n_pop++;
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_pc = sb_q.pop_front();
        check_eq("pop_pc", inst_pc, exp_pc);
        check_eq("pop_data", inst_data, rom_word(exp_pc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int p0;

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    repeat (3) step();

    // reset release: cycle 0
    rst = 1'b1;
    sb_restart(32'h0);
    check_eq("rst_rom_ie", rom_ie, 1'b0);
    check_eq("rst_iaddr", rom_iaddr, 32'h0);
    check_eq("rst_valid", inst_valid, 1'b0);
    check_eq("rst_data", inst_data, 32'h0);
    check_eq("rst_pc", inst_pc, 32'h0);
    step();
    check_eq("c1_rom_ie", rom_ie, 1'b1);
    check_eq("c1_iaddr", rom_iaddr, 32'h0);
    step();
    check_eq("c2_valid", inst_valid, 1'b0);
    step();
    check_eq("c3_valid", inst_valid, 1'b1);
    check_eq("c3_pc", inst_pc, 32'h0);
    check_eq("wrap_pc0", w_inst_pc, 32'hFFFF_FFF8);
    check_eq("wrap_data0", w_inst_data, rom_word(32'hFFFF_FFF8));
`ifdef IFETCH_PERF_EN
    check_eq("perf_c3", perf_stall, 32'd3);
    check_eq("wrap_perf_c3", w_perf_stall, 32'd3);
`endif
    step();
    check_eq("wrap_pc1", w_inst_pc, 32'hFFFF_FFFC);
    step();
    check_eq("wrap_pc2", w_inst_pc, 32'h0000_0000);
    check_eq("wrap_valid2", w_inst_valid, 1'b1);
    repeat (4) step();

    // back-pressure fills the queue to DEPTH
    inst_ready = 1'b0;
    repeat (20) step();
    check_eq("bp_rom_ie", rom_ie, 1'b0);
    check_eq("bp_valid", inst_valid, 1'b1);
    check_eq("bp_queued", 32'(n_issue - n_pop), 32'd4);
    inst_ready = 1'b1;
    p0 = n_pop;
    repeat (12) step();
    check_eq("release_rate", 32'((n_pop - p0) >= 11), 32'd1);

    // redirect with near-full queue and a read in flight
    inst_ready = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0103; inst_ready = 1'b1;
    sb_restart(32'h100);
    step();
    redirect = 1'b0;
    check_eq("rd_valid_n1", inst_valid, 1'b0);
    check_eq("rd_rom_ie_n1", rom_ie, 1'b1);
    check_eq("rd_iaddr_n1", rom_iaddr, 32'h100);
    step();
    check_eq("rd_valid_n2", inst_valid, 1'b0);
    step();
    check_eq("rd_valid_n3", inst_valid, 1'b1);
    check_eq("rd_pc_n3", inst_pc, 32'h100);
    repeat (5) step();

    // back-to-back redirects: the second one wins
    redirect = 1'b1; redirect_pc = 32'h200;
    sb_restart(32'h200);
    step();
    redirect_pc = 32'h300;
    sb_restart(32'h300);
    step();
    redirect = 1'b0;
    check_eq("rr_valid", inst_valid, 1'b0);
    step();
    step();
    check_eq("rr_valid_first", inst_valid, 1'b1);
    check_eq("rr_pc_first", inst_pc, 32'h300);
    repeat (5) step();

    // reset mid-stream
    rst = 1'b0;
    step();
    check_eq("mr_rom_ie", rom_ie, 1'b0);
    check_eq("mr_iaddr", rom_iaddr, 32'h0);
    check_eq("mr_valid", inst_valid, 1'b0);
    check_eq("mr_data", inst_data, 32'h0);
    check_eq("mr_pc", inst_pc, 32'h0);
`ifdef IFETCH_PERF_EN
    check_eq("mr_perf", perf_stall, 32'd0);
`endif
    rst = 1'b1;
    sb_restart(32'h0);
    step();
    check_eq("mr_c1_rom_ie", rom_ie, 1'b1);
    check_eq("mr_c1_iaddr", rom_iaddr, 32'h0);
    step();
    step();
    check_eq("mr_c3_valid", inst_valid, 1'b1);
    check_eq("mr_c3_pc", inst_pc, 32'h0);
`ifdef IFETCH_PERF_EN
    check_eq("mr_perf_c3", perf_stall, 32'd3);
`endif
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
